masked_rand_gen: RTL
====================

Name: masked_rand_gen

Overview:
Fresh-randomness source for the DOM masked AND/OR gates. Produces the SHARES*(SHARES-1)/2 random bits each gate needs on its Z input, one new word per enabled cycle. Uses one 32-bit Fibonacci LFSR lane per random bit. Lanes are loaded through a serial seed handshake and re-seeded on request. Sits directly upstream of the masked gates: ZxDO drives their Z input, and the gates' enable also drives EnxSI here.

Parameters:
SHARES, 2, number of shares of the downstream masked gate (>=2)
RAND_BITS (localparam), SHARES*(SHARES-1)/2, output width = number of LFSR lanes
SEED_LEN (localparam), 32*RAND_BITS, total seed bits per (re)seed

Ports:
ClkxCI  in  1  clock; all state updates on rising edge
RstxBI  in  1  reset, synchronous, active-low
SeedValidxSI  in  1  serial seed bit valid
SeedxDI  in  1  serial seed bit
SeedReadyxSO  out  1  block accepts seed bits (state UNSEEDED)
ReseedxSI  in  1  request re-seed (honoured in RUN only)
EnxSI  in  1  consumer enable; advance all lanes one step
ReadyxSO  out  1  ZxDO valid (state RUN)
ZxDO  out  RAND_BITS  fresh randomness, bit k = MSB of lane k

Behaviour:
- One clock; reset is synchronous and active-low: RstxBI==0 at a rising edge resets the block. Names are ClkxCI and RstxBI.
- Reset state: state=UNSEEDED, all lanes=0, seed counter=0. Outputs: ReadyxSO=0, ZxDO=0, SeedReadyxSO=1 from the first cycle after release.
- Reset mid-seed or mid-run aborts everything and returns to the reset state.
- State vector S={lane[RAND_BITS-1],...,lane[0]}, SEED_LEN bits. Seed counter width is clog2(SEED_LEN+1).
- FSM UNSEEDED:
  - SeedReadyxSO=1, ReadyxSO=0, ZxDO forced 0.
  - A bit is accepted when SeedValidxSI=1: S <= {S[SEED_LEN-2:0], SeedxDI}, count++. The first accepted bit ends up in lane[RAND_BITS-1][31].
  - Cycles with SeedValidxSI=0 change nothing.
  - When the SEED_LEN-th bit is accepted: count<=0, next state FIX.
  - EnxSI and ReseedxSI are ignored.
- FSM FIX (exactly 1 cycle):
  - SeedReadyxSO=0, ReadyxSO=0, ZxDO=0.
  - Any lane equal to 32'h0 is replaced by 32'h0000_0001; other lanes hold.
  - Next state RUN.
- FSM RUN:
  - ReadyxSO=1, SeedReadyxSO=0, ZxDO[k]=lane[k][31] (combinational from lane regs).
  - On EnxSI=1, every lane steps: fb = l[31]^l[21]^l[1]^l[0] (poly x^32+x^22+x^2+x+1); lane <= {lane[30:0], fb}.
  - With EnxSI=0, lanes hold.
  - ReadyxSO rises 2 cycles after the cycle that accepted the final seed bit.
- Re-seed:
  - ReseedxSI=1 in RUN: next state UNSEEDED, count<=0. Lanes keep their value until overwritten by seed shifting.
  - If ReseedxSI and EnxSI are both 1, the step is applied (the word was consumed) and the FSM moves to UNSEEDED in the same edge.
  - ReadyxSO=0 from the next cycle. The consumer must not assert EnxSI while ReadyxSO=0; if it does, EnxSI is ignored.
- Seed bits offered in FIX/RUN are not accepted (SeedReadyxSO=0) and have no effect.
- A stepping lane never reaches 0, because of FIX and the maximal-length polynomial.

Test Plan:
1. Hold RstxBI=0 for 2 cycles, then release: ReadyxSO=0, ZxDO=0, SeedReadyxSO=1. Assert RstxBI=0 again mid-seed (bit 10): counter cleared, lanes=0.
2. SHARES=2 (RAND_BITS=1). Seed 32'h8000_0000, MSB first, on consecutive cycles: ReadyxSO=1 two cycles after the 32nd bit, ZxDO=1. After one EnxSI: lane=32'h0000_0001, ZxDO=0. EnxSI=0 for 5 cycles: ZxDO stays 0, lane unchanged.
3. SHARES=2, all-zero seed: FIX forces lane=32'h0000_0001. First EnxSI gives lane=32'h0000_0003. Never all-zero over 1000 steps; compare each step against a reference model.
4. SHARES=3 (RAND_BITS=3, SEED_LEN=96). Seed bits with random SeedValidxSI gaps, lane2 seed sent first: exactly 96 bits accepted, ReadyxSO rises 2 cycles after bit 96. Each ZxDO[k] matches a per-lane model over 200 enables.
5. RUN with ReseedxSI=1 and EnxSI=1 in the same cycle: lanes stepped once, next cycle ReadyxSO=0, ZxDO=0, SeedReadyxSO=1. Re-seeding with a new value resumes RUN with the new sequence.
6. EnxSI=1 and ReseedxSI=1 held during UNSEEDED and FIX: no lane stepping, no state change beyond seed shifting; seed bits offered during RUN are ignored.

Source files
------------

// File: rtl/masked_rand_gen.sv
// Fresh-randomness source for DOM masked gates: one 32-bit Fibonacci LFSR lane
// per output bit, loaded through a serial seed handshake and re-seedable on request.
module masked_rand_gen #(
  parameter  int SHARES    = 2,
  localparam int RAND_BITS = SHARES * (SHARES - 1) / 2,
  localparam int SEED_LEN  = 32 * RAND_BITS
) (
  input  logic                 ClkxCI,
  input  logic                 RstxBI,
  input  logic                 SeedValidxSI,
  input  logic                 SeedxDI,
  output logic                 SeedReadyxSO,
  input  logic                 ReseedxSI,
  input  logic                 EnxSI,
  output logic                 ReadyxSO,
  output logic [RAND_BITS-1:0] ZxDO
);

  localparam int CNT_W = $clog2(SEED_LEN + 1);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_FIX      = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEED_LEN-1:0] s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // x^32 + x^22 + x^2 + x + 1, maximal length; the all-zero state is excluded by ST_FIX.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    SeedReadyxSO = 1'b0;
    ReadyxSO     = 1'b0;
    ZxDO         = '0;
    case (state_q)
      ST_UNSEEDED: begin
        SeedReadyxSO = 1'b1;
        if (SeedValidxSI) begin
          s_d = {s_q[SEED_LEN-2:0], SeedxDI};
          if (cnt_q == CNT_W'(SEED_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FIX: begin
        for (int unsigned k = 0; k < RAND_BITS; k++) begin
          if (s_q[32*k +: 32] == 32'h0) s_d[32*k +: 32] = 32'h0000_0001;
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ReadyxSO = 1'b1;
        for (int unsigned k = 0; k < RAND_BITS; k++) begin
          ZxDO[k] = s_q[32*k + 31];
        end
        // A word consumed in the same cycle as a reseed request is still stepped.
        if (EnxSI) begin
          for (int unsigned k = 0; k < RAND_BITS; k++) begin
            s_d[32*k +: 32] = lfsr_step(s_q[32*k +: 32]);
          end
        end
        if (ReseedxSI) begin
          state_d = ST_UNSEEDED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_UNSEEDED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      state_q <= ST_UNSEEDED;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
